// File: rtl/hsid_argmin_if.sv
// ---------------------------------------------------------------------------
// hsid_argmin_if
// Bundles the argmin stage's pixel-pass control, the squared-distance beat
// stream and the result/status outputs.
//   master : the side that drives start/library_size and the acc_* stream,
//            and observes busy/done/min_value/min_ref/protocol_err.
//   slave  : the argmin block itself.
// ---------------------------------------------------------------------------
interface hsid_argmin_if #(
    parameter int DATA_WIDTH_ACC   = 48,
    parameter int HSI_LIBRARY_SIZE = 256
);
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE);

    logic                             start;
    logic [HSI_LIBRARY_SIZE_ADDR:0]   library_size;
    logic                             acc_valid;
    logic [DATA_WIDTH_ACC-1:0]        acc_value;
    logic                             acc_last;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] acc_ref;
    logic                             busy;
    logic                             done;
    logic [DATA_WIDTH_ACC-1:0]        min_value;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref;
    logic                             protocol_err;

    modport master (
        output start, library_size, acc_valid, acc_value, acc_last, acc_ref,
        input  busy, done, min_value, min_ref, protocol_err
    );

    modport slave (
        input  start, library_size, acc_valid, acc_value, acc_last, acc_ref,
        output busy, done, min_value, min_ref, protocol_err
    );
endinterface

// File: rtl/hsid_argmin.sv
// ---------------------------------------------------------------------------
// hsid_argmin
// Tracks the minimum accumulated squared distance, and the library reference
// that produced it, over one pixel's pass through the HSI library.
// Only final beats (acc_valid & acc_last) are candidates; partial sums are
// ignored. A one-cycle done pulse presents the winner.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - hsid_argmin_if.slave: start/library_size, acc_* beat stream,
//          busy/done/min_value/min_ref/protocol_err (all registered)
// ---------------------------------------------------------------------------
module hsid_argmin #(
    parameter int DATA_WIDTH_ACC   = 48,
    parameter int HSI_LIBRARY_SIZE = 256
) (
    input  logic         clk,
    input  logic         rst,
    hsid_argmin_if.slave bus
);
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                           r_state;
    state_t                           w_next;
    logic [HSI_LIBRARY_SIZE_ADDR:0]   r_size;
    // One bit wider than the index so a full-size library does not wrap.
    logic [HSI_LIBRARY_SIZE_ADDR:0]   r_cnt;
    logic [HSI_LIBRARY_SIZE_ADDR:0]   w_cnt_inc;
    logic                             w_cand;
    logic                             r_busy;
    logic                             r_done;
    logic [DATA_WIDTH_ACC-1:0]        r_min_value;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] r_min_ref;
    logic                             r_perr;

    assign w_cand    = bus.acc_valid & bus.acc_last;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next = (bus.library_size == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_cand && (w_cnt_inc == r_size))
                    w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_size      <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_min_value <= '1;
            r_min_ref   <= '0;
            r_perr      <= 1'b0;
        end else begin
            r_state <= w_next;
            // Status flags follow the state being entered so they line up
            // with it and stay registered.
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Start wins over a same-cycle stray candidate.
                        r_size      <= bus.library_size;
                        r_cnt       <= '0;
                        r_min_value <= '1;
                        r_min_ref   <= '0;
                        r_perr      <= 1'b0;
                    end else if (w_cand) begin
                        r_perr <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_cand) begin
                        r_cnt <= w_cnt_inc;
                        // Strict compare: ties keep the earlier reference.
                        if (bus.acc_value < r_min_value) begin
                            r_min_value <= bus.acc_value;
                            r_min_ref   <= bus.acc_ref;
                        end
                    end
                end
                S_DONE: begin
                    if (w_cand)
                        r_perr <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.min_value    = r_min_value;
    assign bus.min_ref      = r_min_ref;
    assign bus.protocol_err = r_perr;
endmodule
